// File: rtl/pulsar_pkg.sv
// ============================================================================
// Module  : pulsar_pkg
// Brief   : Shared constants and types for the pulsar emulation / timing chain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pulsar_pkg;

  localparam int BIN_W      = 10;
  localparam int CNT_W      = 32;
  localparam int WID_W      = 16;
  localparam int NBINS      = 1 << BIN_W;
  localparam int MIN_PERIOD = NBINS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } ptg_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] epoch;
    logic [WID_W-1:0] width;
  } cfg_t;

endpackage

`default_nettype wire

// File: rtl/pulse_train_generator_if.sv
// ============================================================================
// Module  : pulse_train_generator_if
// Brief   : Configuration handshake bundle for the pulse train generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_train_generator_if #(
  parameter int CNT_W = 32,
  parameter int WID_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_epoch;
  logic [WID_W-1:0] cfg_width;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_period, cfg_epoch, cfg_width,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_epoch, cfg_width,
    output cfg_ready, cfg_err
  );
endinterface

`default_nettype wire

// File: rtl/phase_bin_tracker.sv
// ============================================================================
// Module  : phase_bin_tracker
// Brief   : Incremental divider giving floor(t * 2**BIN_W / period) per step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_bin_tracker #(
  parameter int CNT_W = 32,
  parameter int BIN_W = 10
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clear,
  input  wire logic             i_advance,
  input  wire logic [CNT_W-1:0] i_period,
  output logic      [BIN_W-1:0] o_bin,
  output logic      [CNT_W:0]   o_rem
);

  localparam logic [CNT_W:0] NBINS_EXT = (CNT_W+1)'(2**BIN_W);

  logic [BIN_W-1:0] r_bin;
  logic [CNT_W:0]   r_rem;
  logic [CNT_W:0]   w_rem_add;
  logic             w_wrap;

  // period >= 2**BIN_W bounds rem below period, so one subtract suffices
  assign w_rem_add = r_rem + NBINS_EXT;
  assign w_wrap    = (w_rem_add >= {1'b0, i_period});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_rem <= '0;
    end else if (i_clear) begin
      r_bin <= '0;
      r_rem <= '0;
    end else if (i_advance) begin
      if (w_wrap) begin
        r_rem <= w_rem_add - {1'b0, i_period};
        r_bin <= r_bin + 1'b1;
      end else begin
        r_rem <= w_rem_add;
      end
    end
  end

  assign o_bin = r_bin;
  assign o_rem = r_rem;

  a_bin_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (i_advance && !i_clear && w_wrap) |-> (r_bin != '1));

endmodule

`default_nettype wire

// File: rtl/pulse_train_generator.sv
// ============================================================================
// Module  : pulse_train_generator
// Brief   : Synthetic pulsar source: periodic pulse train with phase bin output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_generator
  import pulsar_pkg::*;
#(
  parameter int CNT_W = pulsar_pkg::CNT_W,
  parameter int BIN_W = pulsar_pkg::BIN_W,
  parameter int WID_W = pulsar_pkg::WID_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_enable,
  input  wire logic             i_stop,
  pulse_train_generator_if.slave cfg,
  output logic                  o_pulse_start,
  output logic                  o_pulse_out,
  output logic      [BIN_W-1:0] o_phase_bin,
  output logic      [CNT_W-1:0] o_pulse_count,
  output logic                  o_busy
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2**BIN_W);

  ptg_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [WID_W-1:0] r_width, w_width_nxt;
  logic [CNT_W-1:0] r_epoch_cnt, w_epoch_nxt;
  logic [CNT_W-1:0] r_t, w_t_nxt;
  logic             r_pulse_start, w_ps_nxt;
  logic             r_pulse_out, w_po_nxt;
  logic [BIN_W-1:0] r_phase_bin, w_bin_nxt;
  logic [CNT_W-1:0] r_pulse_count, w_cnt_nxt;
  logic             r_cfg_ready, r_cfg_err, w_err_nxt;
  logic             r_busy;
  logic             w_cfg_ok, w_trk_clear, w_trk_adv;
  logic [BIN_W-1:0] w_trk_bin;
  logic [CNT_W:0]   w_trk_rem;

  assign w_cfg_ok = (cfg.cfg_period >= MIN_P) && (cfg.cfg_width != '0) &&
                    (CNT_W'(cfg.cfg_width) < cfg.cfg_period);

  phase_bin_tracker #(.CNT_W(CNT_W), .BIN_W(BIN_W)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_trk_clear),
    .i_advance(w_trk_adv),
    .i_period (r_period),
    .o_bin    (w_trk_bin),
    .o_rem    (w_trk_rem)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period;
    w_width_nxt  = r_width;
    w_epoch_nxt  = r_epoch_cnt;
    w_t_nxt      = r_t;
    w_ps_nxt     = 1'b0;
    w_po_nxt     = 1'b0;
    w_bin_nxt    = r_phase_bin;
    w_cnt_nxt    = r_pulse_count;
    w_err_nxt    = 1'b0;
    w_trk_clear  = 1'b0;
    w_trk_adv    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg.cfg_valid) begin
          if (w_cfg_ok) begin
            w_period_nxt = cfg.cfg_period;
            w_width_nxt  = cfg.cfg_width;
            w_epoch_nxt  = cfg.cfg_epoch;
            w_cnt_nxt    = '0;
            w_state_nxt  = ARMED;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ARMED: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
          w_bin_nxt   = '0;
        end else if (i_enable) begin
          if (r_epoch_cnt != '0) begin
            w_epoch_nxt = r_epoch_cnt - 1'b1;
          end else begin
            w_state_nxt = RUN;
            w_t_nxt     = '0;
            w_bin_nxt   = '0;
            w_trk_clear = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
          w_bin_nxt   = '0;
        end else if (i_enable) begin
          // outputs describe cycle t; counters then step to t+1
          w_ps_nxt  = (r_t == '0);
          w_po_nxt  = (r_t < CNT_W'(r_width));
          w_bin_nxt = w_trk_bin;
          if (w_ps_nxt) w_cnt_nxt = r_pulse_count + 1'b1;
          if (r_t == r_period - 1'b1) begin
            w_t_nxt     = '0;
            w_trk_clear = 1'b1;
          end else begin
            w_t_nxt   = r_t + 1'b1;
            w_trk_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_period      <= '0;
      r_width       <= '0;
      r_epoch_cnt   <= '0;
      r_t           <= '0;
      r_pulse_start <= 1'b0;
      r_pulse_out   <= 1'b0;
      r_phase_bin   <= '0;
      r_pulse_count <= '0;
      r_cfg_ready   <= 1'b1;
      r_cfg_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_period      <= w_period_nxt;
      r_width       <= w_width_nxt;
      r_epoch_cnt   <= w_epoch_nxt;
      r_t           <= w_t_nxt;
      r_pulse_start <= w_ps_nxt;
      r_pulse_out   <= w_po_nxt;
      r_phase_bin   <= w_bin_nxt;
      r_pulse_count <= w_cnt_nxt;
      r_cfg_ready   <= (w_state_nxt == IDLE);
      r_cfg_err     <= w_err_nxt;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  assign cfg.cfg_ready = r_cfg_ready;
  assign cfg.cfg_err   = r_cfg_err;
  assign o_pulse_start = r_pulse_start;
  assign o_pulse_out   = r_pulse_out;
  assign o_phase_bin   = r_phase_bin;
  assign o_pulse_count = r_pulse_count;
  assign o_busy        = r_busy;

  a_rem_bound: assert property (@(posedge clk) disable iff (rst)
    (r_state == RUN) |-> (w_trk_rem < {1'b0, r_period}));

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_generator.sv
// ============================================================================
// Module  : tb_pulse_train_generator
// Brief   : Directed self-checking bench for pulse_train_generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_generator;
  import pulsar_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        stop;
  logic        pulse_start;
  logic        pulse_out;
  logic [9:0]  phase_bin;
  logic [31:0] pulse_count;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_train_generator_if #(.CNT_W(32), .WID_W(16)) cfg_bus ();

  pulse_train_generator dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (enable),
    .i_stop       (stop),
    .cfg          (cfg_bus),
    .o_pulse_start(pulse_start),
    .o_pulse_out  (pulse_out),
    .o_phase_bin  (phase_bin),
    .o_pulse_count(pulse_count),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input cfg_t c);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_period = c.period;
    cfg_bus.cfg_epoch  = c.epoch;
    cfg_bus.cfg_width  = c.width;
    tick();
    cfg_bus.cfg_valid  = 1'b0;
  endtask

  task automatic wait_start(output int n, input int limit);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pulse_start && n < limit);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    cfg_t bad [3];
    int   n, errs, bin3, total;
    logic [9:0] hold_bin;

    rst = 1'b1; enable = 1'b1; stop = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_period = '0;
    cfg_bus.cfg_epoch = '0;   cfg_bus.cfg_width = '0;
    repeat (3) tick();
    check("rst_ready", cfg_bus.cfg_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_pout",  pulse_out, 0);
    check("rst_count", pulse_count, 0);
    #2 rst = 1'b0;
    tick();

    // Test 1: period 2048, width 4, epoch 0
    send_cfg('{period: 32'd2048, epoch: 32'd0, width: 16'd4});
    check("t1_busy",  busy, 1);
    check("t1_ready", cfg_bus.cfg_ready, 0);
    wait_start(n, 100);
    check("t1_latency", n, 2);
    check("t1_pout0",  pulse_out, 1);
    check("t1_bin0",   phase_bin, 0);
    check("t1_count1", pulse_count, 1);
    errs = 0;
    for (int t = 1; t < 2048; t++) begin
      tick();
      if (pulse_start !== 1'b0) errs++;
      if (pulse_out !== (t < 4)) errs++;
      if (phase_bin !== 10'((t * 1024) / 2048)) errs++;
    end
    check("t1_sweep", errs, 0);
    check("t1_bin_last", phase_bin, 1023);
    tick();
    check("t1_wrap_ps",  pulse_start, 1);
    check("t1_wrap_bin", phase_bin, 0);
    check("t1_count2",   pulse_count, 2);
    do_stop();
    check("t1_stop_busy", busy, 0);

    // Test 3: rejected configs
    bad[0] = '{period: 32'd1000, epoch: 32'd0, width: 16'd4};
    bad[1] = '{period: 32'd2048, epoch: 32'd0, width: 16'd0};
    bad[2] = '{period: 32'd2048, epoch: 32'd0, width: 16'd2048};
    foreach (bad[i]) begin
      send_cfg(bad[i]);
      check($sformatf("t3_err%0d", i),   cfg_bus.cfg_err, 1);
      check($sformatf("t3_busy%0d", i),  busy, 0);
      check($sformatf("t3_ready%0d", i), cfg_bus.cfg_ready, 1);
      tick();
      check($sformatf("t3_errclr%0d", i), cfg_bus.cfg_err, 0);
    end
    check("t3_count_hold", pulse_count, 2);

    // Test 2: period 1500, epoch 10
    send_cfg('{period: 32'd1500, epoch: 32'd10, width: 16'd8});
    check("t2_count_clr", pulse_count, 0);
    wait_start(n, 100);
    check("t2_latency", n, 12);
    errs = 0; bin3 = -1;
    for (int t = 1; t < 1500; t++) begin
      tick();
      if (t == 3) bin3 = int'(phase_bin);
      if (pulse_out !== (t < 8)) errs++;
      if (phase_bin !== 10'((t * 1024) / 1500)) errs++;
    end
    check("t2_sweep", errs, 0);
    check("t2_bin_t3", bin3, 2);
    check("t2_bin_last", phase_bin, 1023);
    do_stop();

    // Test 4: enable low for 50 cycles mid-pulse
    send_cfg('{period: 32'd2048, epoch: 32'd0, width: 16'd100});
    wait_start(n, 100);
    check("t4_latency", n, 2);
    repeat (50) tick();
    check("t4_pout_t50", pulse_out, 1);
    check("t4_bin_t50",  phase_bin, 25);
    hold_bin = phase_bin;
    enable = 1'b0;
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pulse_out !== 1'b0 || pulse_start !== 1'b0 || phase_bin !== hold_bin) errs++;
    end
    check("t4_frozen", errs, 0);
    enable = 1'b1;
    tick();
    check("t4_resume_pout", pulse_out, 1);
    check("t4_resume_bin",  phase_bin, 25);
    tick();
    check("t4_resume_bin52", phase_bin, 26);
    wait_start(n, 4000);
    total = 50 + 50 + 2 + n;
    check("t4_stretched", total, 2048 + 50);
    check("t4_count", pulse_count, 2);

    // Test 5: stop at t=700, reconfigure
    repeat (700) tick();
    check("t5_bin_t700", phase_bin, 350);
    do_stop();
    check("t5_busy",  busy, 0);
    check("t5_ready", cfg_bus.cfg_ready, 1);
    check("t5_pout",  pulse_out, 0);
    check("t5_bin",   phase_bin, 0);
    check("t5_hold",  pulse_count, 2);
    send_cfg('{period: 32'd1024, epoch: 32'd5, width: 16'd600});
    check("t5_count_clr", pulse_count, 0);
    wait_start(n, 100);
    check("t5_latency", n, 7);
    check("t5_count1", pulse_count, 1);
    repeat (9) tick();
    check("t5_bin_t9", phase_bin, 9);
    check("t5_pout_t9", pulse_out, 1);

    // Test 6: asynchronous reset mid-RUN
    #3 rst = 1'b1;
    #1;
    check("t6_pout",  pulse_out, 0);
    check("t6_busy",  busy, 0);
    check("t6_ready", cfg_bus.cfg_ready, 1);
    check("t6_count", pulse_count, 0);
    check("t6_bin",   phase_bin, 0);
    repeat (2) tick();
    #3 rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (pulse_start !== 1'b0 || busy !== 1'b0) errs++;
    end
    check("t6_quiet", errs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
